// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants, pattern encodings and FSM state for the camera pattern source
package cam_pkg;

    // Default frame geometry, shared with the capture block
    localparam int DEF_TAM_LINE       = 320;
    localparam int DEF_TAM_ROW        = 120;
    localparam int DEF_BLACK_TAM_LINE = 4;
    localparam int DEF_BLACK_TAM_ROW  = 4;
    localparam int DEF_PCLK_HALF      = 2;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_RAMP  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } cam_state_e;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_pattern_rgb.sv
// rtl/cam_pattern_rgb.sv - combinational pixel colour for the selected test pattern
module cam_pattern_rgb
    import cam_pkg::*;
(
    input  logic [7:0]  x_i,
    input  logic [6:0]  y_i,
    input  logic [2:0]  bar_i,
    input  logic [1:0]  pattern_i,
    input  logic [15:0] color_i,
    output logic [15:0] rgb_o
);

    // The ramp only needs x[7:3] and the checker only bit 3 of each coordinate
    logic unused_coord_bits;
    assign unused_coord_bits = ^{x_i[2:0], y_i[6:4], y_i[2:0]};

    always_comb begin
        rgb_o = color_i;
        case (pattern_i)
            PAT_SOLID: rgb_o = color_i;
            PAT_BARS:  rgb_o = bar_color(bar_i);
            PAT_RAMP:  rgb_o = {x_i[7:3], x_i[7:3], 1'b0, x_i[7:3]};
            default:   rgb_o = (x_i[3] ^ y_i[3]) ? RGB_WHITE : RGB_BLACK;
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// rtl/cam_pattern_gen.sv - OV7670-style RGB565 camera source; CAM_GEN_FRAME_CNT_EN adds frame_cnt stamping
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int TAM_LINE       = DEF_TAM_LINE,
    parameter int TAM_ROW        = DEF_TAM_ROW,
    parameter int BLACK_TAM_LINE = DEF_BLACK_TAM_LINE,
    parameter int BLACK_TAM_ROW  = DEF_BLACK_TAM_ROW,
    parameter int PCLK_HALF      = DEF_PCLK_HALF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern,
    input  logic [15:0] color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic        busy
`ifdef CAM_GEN_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    localparam int LINE_TOT = TAM_LINE + BLACK_TAM_LINE;
    localparam int ROW_TOT  = TAM_ROW + BLACK_TAM_ROW;
    localparam int LW       = $clog2(LINE_TOT);
    localparam int RW       = $clog2(ROW_TOT);
    localparam int DW       = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;

    localparam logic [LW-1:0] LINE_LAST   = LW'(LINE_TOT - 1);
    localparam logic [LW-1:0] LINE_ACT    = LW'(TAM_LINE);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROW_TOT - 1);
    localparam logic [RW-1:0] ROW_ACT0    = RW'(BLACK_TAM_ROW);
    localparam logic [RW-1:0] VS_ROWS     = RW'(BLACK_TAM_ROW / 2);
    localparam logic [DW-1:0] DIV_LAST    = DW'(PCLK_HALF - 1);
    localparam logic [4:0]    BAR_PX_LAST = 5'd19;

    logic [DW-1:0] div_q, div_d;
    logic          pclk_q, pclk_d;
    logic          div_wrap, fall_tick;
    cam_state_e    state_q, state_d;
    logic [LW-1:0] line_q, line_d;
    logic [RW-1:0] row_q, row_d;
    logic [2:0]    bar_q, bar_d;
    logic [4:0]    bar_px_q, bar_px_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   color_q, color_d;
    logic          done_q, done_d;
    logic          last_byte, start;
    logic          href;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [15:0]   rgb;
    logic [7:0]    pattern_byte, px_byte;

    // Divider: everything except CAM_pclk moves only on the tick that drives pclk low
    assign div_wrap  = (div_q == DIV_LAST);
    assign div_d     = div_wrap ? '0 : div_q + 1'b1;
    assign pclk_d    = pclk_q ^ div_wrap;
    assign fall_tick = div_wrap & pclk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            pclk_q <= pclk_d;
        end
    end

    assign last_byte = (state_q == ST_FRAME) && (line_q == LINE_LAST) && (row_q == ROW_LAST);
    assign start     = fall_tick && en && ((state_q == ST_IDLE) || last_byte);
    assign done_d    = fall_tick && last_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (fall_tick) begin
            case (state_q)
                ST_IDLE:  if (en) state_d = ST_FRAME;
                ST_FRAME: if (last_byte && !en) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Counters wrap to 0 on the final byte, so a back-to-back start needs no explicit clear
    always_comb begin
        line_d   = line_q;
        row_d    = row_q;
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        pat_d    = pat_q;
        color_d  = color_q;
        if (fall_tick && state_q == ST_FRAME) begin
            if (line_q == LINE_LAST) begin
                line_d   = '0;
                bar_d    = '0;
                bar_px_d = '0;
                row_d    = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                line_d = line_q + 1'b1;
                if (line_q[0]) begin
                    if (bar_px_q == BAR_PX_LAST) begin
                        bar_px_d = '0;
                        bar_d    = bar_q + 1'b1;
                    end else begin
                        bar_px_d = bar_px_q + 1'b1;
                    end
                end
            end
        end
        if (start) begin
            pat_d   = pattern;
            color_d = color;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_q   <= '0;
            row_q    <= '0;
            bar_q    <= '0;
            bar_px_q <= '0;
            pat_q    <= PAT_SOLID;
            color_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            line_q   <= line_d;
            row_q    <= row_d;
            bar_q    <= bar_d;
            bar_px_q <= bar_px_d;
            pat_q    <= pat_d;
            color_q  <= color_d;
            done_q   <= done_d;
        end
    end

    assign x = 8'(line_q >> 1);
    assign y = 7'(row_q - ROW_ACT0);

    cam_pattern_rgb u_rgb (
        .x_i       (x),
        .y_i       (y),
        .bar_i     (bar_q),
        .pattern_i (pat_q),
        .color_i   (color_q),
        .rgb_o     (rgb)
    );

    assign pattern_byte = line_q[0] ? rgb[7:0] : rgb[15:8];

`ifdef CAM_GEN_FRAME_CNT_EN
    logic [7:0] fcnt_q, fcnt_d;

    assign fcnt_d    = done_d ? fcnt_q + 8'd1 : fcnt_q;
    assign frame_cnt = fcnt_q;
    assign px_byte   = (row_q == ROW_ACT0 && line_q == '0) ? fcnt_q : pattern_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end
`else
    assign px_byte = pattern_byte;
`endif

    always_comb begin
        busy        = (state_q == ST_FRAME);
        CAM_vsync   = (state_q == ST_FRAME) && (row_q < VS_ROWS);
        href        = (state_q == ST_FRAME) && (row_q >= ROW_ACT0) && (line_q < LINE_ACT);
        CAM_href    = href;
        CAM_px_data = href ? px_byte : 8'h00;
    end

    assign CAM_pclk   = pclk_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// tb/tb_cam_pattern_gen.sv - directed bench for cam_pattern_gen with a shortened 10-row frame
module tb_cam_pattern_gen;

    localparam int TR = 10;
    localparam int LT = 324;
    localparam int RT = 14;
    localparam int NB = LT * RT;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] color = 16'h0000;
    logic        CAM_pclk, CAM_vsync, CAM_href, frame_done, busy;
    logic [7:0]  CAM_px_data;
`ifdef CAM_GEN_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;
    logic [9:0] cap [0:RT-1][0:LT-1];

    always #5 clk = ~clk;

    cam_pattern_gen #(
        .TAM_ROW   (TR),
        .PCLK_HALF (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pattern     (pattern),
        .color       (color),
        .CAM_pclk    (CAM_pclk),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
        .frame_done  (frame_done),
        .busy        (busy)
`ifdef CAM_GEN_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    task automatic next_byte(output bit ok);
        int n;
        n = 0;
        while (CAM_pclk !== 1'b0 && n < 8) begin @(negedge clk); n++; end
        while (CAM_pclk !== 1'b1 && n < 16) begin @(negedge clk); n++; end
        ok = (CAM_pclk === 1'b1);
    endtask

    task automatic wait_start(output bit ok);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        ok = (busy === 1'b1);
    endtask

    task automatic capture(input int nbytes, input int act_idx, input bit act_en,
                           input logic [1:0] act_pat, output bit ok);
        bit b;
        ok = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            if (i == act_idx) begin
                en = act_en;
                pattern = act_pat;
            end
            next_byte(b);
            if (!b) begin
                ok = 1'b0;
                return;
            end
            cap[i / LT][i % LT] = {CAM_vsync, CAM_href, CAM_px_data};
        end
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        obs = {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy};
        n_total++;
        if (obs !== 13'h0) $display("FAIL reset_outputs got %h exp 0000", obs); else n_pass++;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        n_total++;
        if ({busy, CAM_vsync} !== 2'b00) $display("FAIL idle_no_en got %b exp 00", {busy, CAM_vsync});
        else n_pass++;
    endtask

    task automatic test_solid();
        bit ok;
        int pulses, bad, blank_bad;
        logic prev;
        pattern = 2'd0;
        color = 16'hF800;
        en = 1'b1;
        wait_start(ok);
        n_total++;
        if (!ok) $display("FAIL solid_start busy got %b exp 1", busy); else n_pass++;
        color = 16'h07E0;
        capture(NB, 5, 1'b1, 2'd1, ok);
        n_total++;
        if (!ok) $display("FAIL solid_capture pclk stalled got 0 exp 1"); else n_pass++;
        for (int r = 0; r < RT; r++) begin
            n_total++;
            if (cap[r][0][9:8] !== {r < 2, r >= 4})
                $display("FAIL solid_sync row %0d got %b exp %b", r, cap[r][0][9:8], {r < 2, r >= 4});
            else n_pass++;
        end
        n_total++;
        if ({cap[4][319][8], cap[4][320][8]} !== 2'b10)
            $display("FAIL solid_href_end got %b exp 10", {cap[4][319][8], cap[4][320][8]});
        else n_pass++;
        pulses = 0; bad = 0; blank_bad = 0; prev = 1'b0;
        for (int r = 0; r < RT; r++) begin
            for (int l = 0; l < LT; l++) begin
                if (cap[r][l][8] && !prev) pulses++;
                prev = cap[r][l][8];
                if (!cap[r][l][8] && cap[r][l][7:0] != 8'h00) blank_bad++;
                if (r >= 4 && l < 320 && !(FC && r == 4 && l == 0)
                    && cap[r][l][7:0] != ((l % 2 == 0) ? 8'hF8 : 8'h00)) bad++;
            end
        end
        n_total++;
        if (pulses !== TR) $display("FAIL solid_href_pulses got %0d exp %0d", pulses, TR); else n_pass++;
        n_total++;
        if (bad !== 0) $display("FAIL solid_data bad bytes got %0d exp 0", bad); else n_pass++;
        n_total++;
        if (blank_bad !== 0) $display("FAIL solid_blank_zero got %0d exp 0", blank_bad); else n_pass++;
        n_total++;
        if (cap[4][0][7:0] !== (FC ? 8'h00 : 8'hF8))
            $display("FAIL solid_first_byte got %h exp %h", cap[4][0][7:0], FC ? 8'h00 : 8'hF8);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({frame_done, busy} !== 2'b11) $display("FAIL solid_done got %b exp 11", {frame_done, busy});
        else n_pass++;
    endtask

    task automatic test_back_to_back_bars();
        bit ok;
        logic [15:0] got;
        int          tr [12] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 4};
        int          tx [12] = '{0, 19, 20, 39, 40, 60, 80, 100, 120, 140, 159, 20};
        logic [15:0] tc [12] = '{16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000, 16'h0000, 16'hFFE0};
        capture(NB, 5, 1'b1, 2'd3, ok);
        n_total++;
        if (!ok) $display("FAIL bars_capture pclk stalled got 0 exp 1"); else n_pass++;
        n_total++;
        if (cap[0][0][9] !== 1'b1) $display("FAIL bars_vsync_no_gap got %b exp 1", cap[0][0][9]); else n_pass++;
        for (int k = 0; k < 12; k++) begin
            got = {cap[tr[k]][2 * tx[k]][7:0], cap[tr[k]][2 * tx[k] + 1][7:0]};
            n_total++;
            if (got !== tc[k]) $display("FAIL bars_px row %0d x %0d got %h exp %h", tr[k], tx[k], got, tc[k]);
            else n_pass++;
        end
        n_total++;
        if (cap[4][0][7:0] !== (FC ? 8'h01 : 8'hFF))
            $display("FAIL bars_first_byte got %h exp %h", cap[4][0][7:0], FC ? 8'h01 : 8'hFF);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({frame_done, busy} !== 2'b11) $display("FAIL bars_done got %b exp 11", {frame_done, busy});
        else n_pass++;
    endtask

    task automatic test_checker();
        bit ok;
        logic [15:0] got;
        int          tr [6] = '{4, 12, 4, 12, 5, 13};
        int          tx [6] = '{8, 8, 1, 0, 16, 9};
        logic [15:0] tc [6] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        capture(NB, 5, 1'b1, 2'd2, ok);
        n_total++;
        if (!ok) $display("FAIL check_capture pclk stalled got 0 exp 1"); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            got = {cap[tr[k]][2 * tx[k]][7:0], cap[tr[k]][2 * tx[k] + 1][7:0]};
            n_total++;
            if (got !== tc[k]) $display("FAIL check_px row %0d x %0d got %h exp %h", tr[k], tx[k], got, tc[k]);
            else n_pass++;
        end
        n_total++;
        if (cap[4][0][7:0] !== (FC ? 8'h02 : 8'h00))
            $display("FAIL check_first_byte got %h exp %h", cap[4][0][7:0], FC ? 8'h02 : 8'h00);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({frame_done, busy} !== 2'b11) $display("FAIL check_done got %b exp 11", {frame_done, busy});
        else n_pass++;
    endtask

    task automatic test_drop_en();
        bit ok;
        int idle_bad;
        logic [15:0] got;
        int          tr [5] = '{4, 4, 11, 11, 13};
        int          tx [5] = '{1, 8, 8, 159, 100};
        logic [15:0] tc [5] = '{16'h0000, 16'h0841, 16'h0841, 16'h9CD3, 16'h630C};
`ifdef CAM_GEN_FRAME_CNT_EN
        n_total++;
        if (frame_cnt !== 8'd3) $display("FAIL frame_cnt_3 got %0d exp 3", frame_cnt); else n_pass++;
`endif
        capture(NB, 7 * LT, 1'b0, 2'd0, ok);
        n_total++;
        if (!ok) $display("FAIL drop_capture pclk stalled got 0 exp 1"); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            got = {cap[tr[k]][2 * tx[k]][7:0], cap[tr[k]][2 * tx[k] + 1][7:0]};
            n_total++;
            if (got !== tc[k]) $display("FAIL ramp_px row %0d x %0d got %h exp %h", tr[k], tx[k], got, tc[k]);
            else n_pass++;
        end
        n_total++;
        if (cap[4][0][7:0] !== (FC ? 8'h03 : 8'h00))
            $display("FAIL ramp_first_byte got %h exp %h", cap[4][0][7:0], FC ? 8'h03 : 8'h00);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({frame_done, busy} !== 2'b10) $display("FAIL drop_done got %b exp 10", {frame_done, busy});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (frame_done !== 1'b0) $display("FAIL done_width got %b exp 0", frame_done); else n_pass++;
        idle_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ({CAM_vsync, CAM_href, CAM_px_data, busy, frame_done} !== 12'h0) idle_bad++;
        end
        n_total++;
        if (idle_bad !== 0) $display("FAIL idle_after_drop got %0d exp 0", idle_bad); else n_pass++;
`ifdef CAM_GEN_FRAME_CNT_EN
        n_total++;
        if (frame_cnt !== 8'd4) $display("FAIL frame_cnt_4 got %0d exp 4", frame_cnt); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        logic [12:0] obs;
        en = 1'b1;
        pattern = 2'd2;
        wait_start(ok);
        n_total++;
        if (!ok) $display("FAIL rst_mid_start busy got %b exp 1", busy); else n_pass++;
        capture(6 * LT + 101, -1, 1'b1, 2'd2, ok);
        n_total++;
        if (cap[6][100] !== {2'b01, 8'h31}) $display("FAIL rst_mid_pre got %h exp 031", cap[6][100]);
        else n_pass++;
        rst = 1'b0;
        #1;
        obs = {CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, busy};
        n_total++;
        if (obs !== 13'h0) $display("FAIL rst_mid_outputs got %h exp 0000", obs); else n_pass++;
`ifdef CAM_GEN_FRAME_CNT_EN
        n_total++;
        if (frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); else n_pass++;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_start(ok);
        n_total++;
        if (!ok) $display("FAIL restart busy got %b exp 1", busy); else n_pass++;
        capture(NB, 10 * LT, 1'b0, 2'd2, ok);
        n_total++;
        if (!ok) $display("FAIL restart_capture pclk stalled got 0 exp 1"); else n_pass++;
        n_total++;
        if ({cap[0][0][9], cap[1][0][9], cap[2][0][9], cap[3][0][8], cap[4][0][8]} !== 5'b11001)
            $display("FAIL restart_sync got %b exp 11001",
                     {cap[0][0][9], cap[1][0][9], cap[2][0][9], cap[3][0][8], cap[4][0][8]});
        else n_pass++;
        n_total++;
        if ({cap[4][16][7:0], cap[4][17][7:0]} !== 16'h0841)
            $display("FAIL restart_ramp got %h exp 0841", {cap[4][16][7:0], cap[4][17][7:0]});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({frame_done, busy} !== 2'b10) $display("FAIL restart_done got %b exp 10", {frame_done, busy});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_solid();
        test_back_to_back_bars();
        test_checker();
        test_drop_en();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cam_pattern_gen.md
# cam_pattern_gen

Synthesizable OV7670-style camera source: drives CAM_pclk, CAM_vsync, CAM_href and CAM_px_data with the same 160x120 RGB565 framing the capture path consumes (two bytes per pixel, 320 bytes per line). It replaces the physical camera on the board for bring-up, and serves as the shared stimulus source for capture and VGA-path benches. Four built-in test patterns give deterministic, checkable frame-buffer contents.

## Interface
- TAM_LINE, 320: active bytes per line (160 px x 2).
- TAM_ROW, 120: active rows per frame.
- BLACK_TAM_LINE, 4: blanking bytes per line.
- BLACK_TAM_ROW, 4: blanking rows at frame start; vsync high for the first BLACK_TAM_ROW/2 of them.
- PCLK_HALF, 2: clk cycles per CAM_pclk half-period (>=1).
- clk  in  1  system clock; only clock in the block.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run request; sampled only at frame boundaries.
- pattern  in  2  0 solid, 1 color bars, 2 gray ramp, 3 checkerboard.
- color  in  16  RGB565 value for the solid pattern.
- CAM_pclk  out  1  generated pixel clock, free-running after reset.
- CAM_vsync  out  1  frame sync, active high.
- CAM_href  out  1  line-valid, active high.
- CAM_px_data  out  8  pixel byte.
- frame_done  out  1  one-clk pulse after the last byte of a frame.
- busy  out  1  high while a frame is in progress.

## Operation
- Divider counts 0..PCLK_HALF-1 and toggles CAM_pclk at wrap. Every output except CAM_pclk updates only on the clk edge that drives CAM_pclk low, so data is stable across the receiver's rising edge.
- Counters: line_cnt 0..TAM_LINE+BLACK_TAM_LINE-1 (bytes) and row_cnt 0..TAM_ROW+BLACK_TAM_ROW-1. row_cnt advances when line_cnt wraps.
- FSM:
  - IDLE: counters held at 0, vsync/href/data at 0. On a falling-edge tick with en=1, latch pattern and color and go to FRAME.
  - FRAME: counters run. After the final byte (last row, last line_cnt), pulse frame_done and go to IDLE.
  - IDLE re-checks en on the very next falling tick, so back-to-back frames have no gap beyond blanking.
- en deasserted mid-frame: the current frame completes; no truncation.
- CAM_vsync = FRAME && row_cnt < BLACK_TAM_ROW/2.
- CAM_href = FRAME && row_cnt >= BLACK_TAM_ROW && line_cnt < TAM_LINE.
- Pixel coordinates: x = line_cnt>>1 (0..159), y = row_cnt-BLACK_TAM_ROW (0..119).
- Byte order: even line_cnt sends {R[4:0],G[5:3]}; odd sends {G[2:0],B[4:0]}. CAM_px_data = 0 whenever href is low.
- Patterns:
  - Solid: the latched color.
  - Bars: 8 bars of 20 px each. A bar counter resets each line and advances every 20 px (no divider). Colors in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Ramp: R=x[7:3], G={x[7:3],0}, B=x[7:3].
  - Checker: (x[3]^y[3]) ? FFFF : 0000.
- busy = (state==FRAME).

## Timing
- Reset values: CAM_pclk=0, CAM_vsync=0, CAM_href=0, CAM_px_data=0, frame_done=0, busy=0. State IDLE, all counters 0.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The next frame starts from row 0.
- First vsync: asserted on the first pclk falling edge on which en=1 is seen in IDLE.
- Frame length: (TAM_LINE+BLACK_TAM_LINE)x(TAM_ROW+BLACK_TAM_ROW) pclk periods, i.e. 324x124 with defaults.
- Each pclk period = 2xPCLK_HALF clk cycles.
- frame_done: high for exactly one clk, on the falling tick following the last byte. Coincides with the IDLE->FRAME decision for the next frame.
- pattern and color changes take effect only at the next frame start.

## Configuration
- CAM_GEN_FRAME_CNT_EN defined:
  - Adds output frame_cnt[7:0]: increments at each frame_done and wraps 255->0; reset value 0.
  - The first active byte of each frame (y=0, line_cnt=0) is replaced by frame_cnt, for dropped-frame detection.
- Undefined: no frame_cnt port, no counter logic, and the first byte carries the pattern.

## Structure
- Shared package cam_pkg holds:
  - RGB565 bar color constants.
  - Pattern encodings PAT_SOLID=0, PAT_BARS=1, PAT_RAMP=2, PAT_CHECK=3.
  - FSM state encoding.
  - Default frame geometry constants shared with the capture block.
- One sub-module, cam_pattern_rgb: combinational (x, y, bar index, pattern, color) -> 16-bit RGB565. The top keeps the divider, counters, FSM and byte muxing.

## Test plan
- Reset, then en=1, pattern=0, color=F800 -> vsync high 2 rows, href first rises at row 4; bytes alternate F8, 00 for 160 pairs per line; 120 href pulses per frame.
- pattern=1 -> line bytes: 20 pairs FF FF, then FF E0, 07 FF, ... ending 00 00; bar transitions at x=20,40,...,140.
- pattern=3 -> y=0, x=8 emits FF FF; y=8, x=8 emits 00 00.
- Drop en and change pattern at row 60 -> frame completes with the old pattern; frame_done pulses once; busy falls; outputs stay 0 afterwards.
- Assert rst at row 50, line_cnt 100 -> all outputs 0 within the same clk. After release with en=1, vsync restarts at row 0.
- With CAM_GEN_FRAME_CNT_EN: 3 consecutive frames -> first active byte 00, 01, 02; frame_cnt ends at 3.
